// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: control-bit indices common with decode/execute,
// the MEM-stage FSM encoding and the MEM/WB payload.
package mem_access_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned MEM_CTRL_W = 4;
  localparam int unsigned WB_CTRL_W  = 2;

  localparam int unsigned MEM_READ_BIT     = 0;
  localparam int unsigned MEM_WRITE_BIT    = 1;
  localparam int unsigned BRANCH_BIT       = 2;
  localparam int unsigned BRANCH_SENSE_BIT = 3;

  localparam int unsigned WB_MEM_TO_REG_BIT = 0;
  localparam int unsigned WB_REG_WRITE_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]      alu_out;
    logic [XLEN-1:0]      mem_out;
    logic [REG_AW-1:0]    write_reg;
    logic [WB_CTRL_W-1:0] wb_ctrl;
  } mem_wb_t;

  // Data memory is word addressed; byte offset is dropped.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_branch_resolve.sv
// Resolves the branch in MEM against its prediction: flush, recovery PC and predictor training.
module branch_resolve
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0]       alu_out,
  input  logic [MEM_CTRL_W-1:0] mem_ctrl,
  input  logic                  prediction,
  input  logic [XLEN-1:0]       recover_taken,
  input  logic [XLEN-1:0]       recover_not_taken,
  output logic                  flush,
  output logic [XLEN-1:0]       pc_recover,
  output logic                  bp_update,
  output logic                  bp_taken
);

  logic taken;

  always_comb begin
    taken      = mem_ctrl[BRANCH_SENSE_BIT] ? (alu_out != '0) : (alu_out == '0);
    flush      = 1'b0;
    pc_recover = '0;
    bp_update  = 1'b0;
    bp_taken   = 1'b0;
    if (mem_ctrl[BRANCH_BIT]) begin
      bp_update  = 1'b1;
      bp_taken   = taken;
      flush      = (taken != prediction);
      pc_recover = taken ? recover_taken : recover_not_taken;
    end
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: data-memory req/ack access with stall and timeout, branch resolution,
// and the MEM/WB register.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       ALU_OUT,
  input  logic [XLEN-1:0]       RT_DATA,
  input  logic [REG_AW-1:0]     WRITE_REG,
  input  logic [MEM_CTRL_W-1:0] MEM_CTRL,
  input  logic [WB_CTRL_W-1:0]  WB_CTRL,
  input  logic                  prediction,
  input  logic [XLEN-1:0]       RECOVER_TAKEN,
  input  logic [XLEN-1:0]       RECOVER_NOT_TAKEN,
  output logic                  DMEM_REQ,
  output logic                  DMEM_WE,
  output logic [XLEN-1:0]       DMEM_ADDR,
  output logic [XLEN-1:0]       DMEM_WDATA,
  input  logic [XLEN-1:0]       DMEM_RDATA,
  input  logic                  DMEM_ACK,
  output logic                  cache_stall,
  output logic                  flush,
  output logic [XLEN-1:0]       PC_RECOVER,
  output logic                  BP_UPDATE,
  output logic                  BP_TAKEN,
  output logic [XLEN-1:0]       MEM_FWD_DATA,
  output logic                  BUS_ERR,
  output logic [XLEN-1:0]       REG_ALU_OUT,
  output logic [XLEN-1:0]       REG_MEM_OUT,
  output logic [REG_AW-1:0]     REG_WRITE_REG,
  output logic [WB_CTRL_W-1:0]  REG_WB_CTRL
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [XLEN-1:0]  rbuf, rbuf_nxt;
  logic             bus_err, bus_err_nxt;
  mem_wb_t          mem_wb, mem_wb_nxt;

  logic             access;
  logic             is_store;
  logic             req_c;
  logic             stall_c;
  logic             load_wb;
  logic [XLEN-1:0]  wb_mem_out;
  logic [XLEN-1:0]  ack_data;

  assign access   = MEM_CTRL[MEM_READ_BIT] | MEM_CTRL[MEM_WRITE_BIT];
  assign is_store = MEM_CTRL[MEM_WRITE_BIT];
  // Stores return no data to write-back.
  assign ack_data = is_store ? '0 : DMEM_RDATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rbuf    <= '0;
      bus_err <= 1'b0;
      mem_wb  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rbuf    <= rbuf_nxt;
      bus_err <= bus_err_nxt;
      mem_wb  <= mem_wb_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rbuf_nxt    = rbuf;
    bus_err_nxt = bus_err;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    load_wb     = 1'b0;
    wb_mem_out  = '0;
    unique case (state)
      ST_IDLE: begin
        if (access) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (DMEM_ACK) begin
            rbuf_nxt  = ack_data;
            state_nxt = ST_RESUME;
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_WAIT;
          end
        end else begin
          load_wb = 1'b1;
        end
      end
      ST_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (DMEM_ACK) begin
          rbuf_nxt  = ack_data;
          state_nxt = ST_RESUME;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          bus_err_nxt = 1'b1;
          rbuf_nxt    = '0;
          state_nxt   = ST_RESUME;
        end
      end
      ST_RESUME: begin
        load_wb    = 1'b1;
        wb_mem_out = rbuf;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    mem_wb_nxt = mem_wb;
    if (load_wb) begin
      mem_wb_nxt.alu_out   = ALU_OUT;
      mem_wb_nxt.mem_out   = wb_mem_out;
      mem_wb_nxt.write_reg = WRITE_REG;
      mem_wb_nxt.wb_ctrl   = WB_CTRL;
    end
  end

  // Reset kills an in-flight request in the same cycle, even with EX/MEM still holding an access.
  assign DMEM_REQ     = req_c & reset;
  assign cache_stall  = stall_c & reset;
  assign DMEM_WE      = DMEM_REQ & is_store;
  assign DMEM_ADDR    = word_addr(ALU_OUT);
  assign DMEM_WDATA   = RT_DATA;
  assign MEM_FWD_DATA = ALU_OUT;

  assign BUS_ERR       = bus_err;
  assign REG_ALU_OUT   = mem_wb.alu_out;
  assign REG_MEM_OUT   = mem_wb.mem_out;
  assign REG_WRITE_REG = mem_wb.write_reg;
  assign REG_WB_CTRL   = mem_wb.wb_ctrl;

  branch_resolve u_branch_resolve (
    .alu_out           (ALU_OUT),
    .mem_ctrl          (MEM_CTRL),
    .prediction        (prediction),
    .recover_taken     (RECOVER_TAKEN),
    .recover_not_taken (RECOVER_NOT_TAKEN),
    .flush             (flush),
    .pc_recover        (PC_RECOVER),
    .bp_update         (BP_UPDATE),
    .bp_taken          (BP_TAKEN)
  );

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, branches, timeout and asynchronous reset.
module tb_mem_access;
  import mem_access_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [XLEN-1:0]       ALU_OUT, RT_DATA, RECOVER_TAKEN, RECOVER_NOT_TAKEN, DMEM_RDATA;
  logic [REG_AW-1:0]     WRITE_REG;
  logic [MEM_CTRL_W-1:0] MEM_CTRL;
  logic [WB_CTRL_W-1:0]  WB_CTRL;
  logic                  prediction, DMEM_ACK;
  logic                  DMEM_REQ, DMEM_WE, cache_stall, flush, BP_UPDATE, BP_TAKEN, BUS_ERR;
  logic [XLEN-1:0]       DMEM_ADDR, DMEM_WDATA, PC_RECOVER, MEM_FWD_DATA, REG_ALU_OUT, REG_MEM_OUT;
  logic [REG_AW-1:0]     REG_WRITE_REG;
  logic [WB_CTRL_W-1:0]  REG_WB_CTRL;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned n;

  mem_access #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .ALU_OUT(ALU_OUT), .RT_DATA(RT_DATA), .WRITE_REG(WRITE_REG),
    .MEM_CTRL(MEM_CTRL), .WB_CTRL(WB_CTRL), .prediction(prediction),
    .RECOVER_TAKEN(RECOVER_TAKEN), .RECOVER_NOT_TAKEN(RECOVER_NOT_TAKEN),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK), .cache_stall(cache_stall), .flush(flush),
    .PC_RECOVER(PC_RECOVER), .BP_UPDATE(BP_UPDATE), .BP_TAKEN(BP_TAKEN),
    .MEM_FWD_DATA(MEM_FWD_DATA), .BUS_ERR(BUS_ERR), .REG_ALU_OUT(REG_ALU_OUT),
    .REG_MEM_OUT(REG_MEM_OUT), .REG_WRITE_REG(REG_WRITE_REG), .REG_WB_CTRL(REG_WB_CTRL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop(input logic [31:0] alu, input logic [4:0] rd);
    ALU_OUT   = alu;
    RT_DATA   = '0;
    WRITE_REG = rd;
    MEM_CTRL  = '0;
    WB_CTRL   = '0;
    WB_CTRL[WB_REG_WRITE_BIT] = 1'b1;
    DMEM_ACK  = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
    set_nop(addr, rd);
    MEM_CTRL[MEM_READ_BIT]    = 1'b1;
    WB_CTRL[WB_MEM_TO_REG_BIT] = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_nop(32'h0, 5'd0);
    prediction = 1'b0;
    RECOVER_TAKEN = 32'h0000_0400;
    RECOVER_NOT_TAKEN = 32'h0000_0204;
    DMEM_RDATA = '0;
    #12;
    chk("rst_req", 32'(DMEM_REQ), 32'd0);
    chk("rst_stall", 32'(cache_stall), 32'd0);
    chk("rst_reg_alu", REG_ALU_OUT, 32'h0);
    chk("rst_bus_err", 32'(BUS_ERR), 32'd0);
    tick;
    reset = 1'b1;

    // Plain ALU instruction: one cycle through the stage.
    set_nop(32'h0000_1234, 5'd3);
    #1;
    chk("alu_stall", 32'(cache_stall), 32'd0);
    chk("alu_fwd", MEM_FWD_DATA, 32'h0000_1234);
    tick;
    chk("alu_reg_alu", REG_ALU_OUT, 32'h0000_1234);
    chk("alu_reg_mem", REG_MEM_OUT, 32'h0);
    chk("alu_reg_wr", 32'(REG_WRITE_REG), 32'd3);
    chk("alu_reg_wb", 32'(REG_WB_CTRL), 32'd2);

    // Load with ack three cycles after issue.
    set_load(32'h0000_0100, 5'd7);
    DMEM_RDATA = 32'hDEAD_BEEF;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      DMEM_ACK = (i == 3);
      #1;
      if (!cache_stall) break;
      if (i == 0) begin
        chk("ld_req", 32'(DMEM_REQ), 32'd1);
        chk("ld_we", 32'(DMEM_WE), 32'd0);
        chk("ld_addr", DMEM_ADDR, 32'h0000_0100);
      end
      n++;
      tick;
    end
    DMEM_ACK = 1'b0;
    chk("ld_stall_cycles", n, 32'd4);
    chk("ld_resume_req", 32'(DMEM_REQ), 32'd0);
    chk("ld_wb_held", REG_ALU_OUT, 32'h0000_1234);
    tick;
    chk("ld_reg_mem", REG_MEM_OUT, 32'hDEAD_BEEF);
    chk("ld_reg_alu", REG_ALU_OUT, 32'h0000_0100);
    chk("ld_reg_wr", 32'(REG_WRITE_REG), 32'd7);

    // Store acked in the issue cycle.
    set_nop(32'h0000_0107, 5'd0);
    MEM_CTRL[MEM_WRITE_BIT] = 1'b1;
    RT_DATA  = 32'h0000_0055;
    DMEM_ACK = 1'b1;
    #1;
    chk("st_addr", DMEM_ADDR, 32'h0000_0104);
    chk("st_we", 32'(DMEM_WE), 32'd1);
    chk("st_wdata", DMEM_WDATA, 32'h0000_0055);
    chk("st_stall", 32'(cache_stall), 32'd1);
    tick;
    DMEM_ACK = 1'b0;
    #1;
    chk("st_resume_stall", 32'(cache_stall), 32'd0);
    tick;
    chk("st_reg_alu", REG_ALU_OUT, 32'h0000_0107);

    // Load (ack in issue cycle) then an add: add reaches MEM/WB one cycle after the load.
    set_load(32'h0000_0200, 5'd4);
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 32'hCAFE_0001;
    tick;
    DMEM_ACK = 1'b0;
    tick;
    chk("b2b_ld_mem", REG_MEM_OUT, 32'hCAFE_0001);
    chk("b2b_ld_wr", 32'(REG_WRITE_REG), 32'd4);
    set_nop(32'h0000_0042, 5'd9);
    #1;
    chk("b2b_add_stall", 32'(cache_stall), 32'd0);
    tick;
    chk("b2b_add_alu", REG_ALU_OUT, 32'h0000_0042);
    chk("b2b_add_wr", 32'(REG_WRITE_REG), 32'd9);
    chk("b2b_add_mem", REG_MEM_OUT, 32'h0);

    // beq taken, predicted not taken.
    set_nop(32'h0, 5'd2);
    MEM_CTRL[BRANCH_BIT] = 1'b1;
    prediction = 1'b0;
    #1;
    chk("beq_flush", 32'(flush), 32'd1);
    chk("beq_pc", PC_RECOVER, 32'h0000_0400);
    chk("beq_bp_taken", 32'(BP_TAKEN), 32'd1);
    chk("beq_bp_update", 32'(BP_UPDATE), 32'd1);
    chk("beq_stall", 32'(cache_stall), 32'd0);
    tick;
    chk("beq_wb_kept", 32'(REG_WRITE_REG), 32'd2);
    // bne taken, predicted taken.
    ALU_OUT = 32'd5;
    MEM_CTRL[BRANCH_SENSE_BIT] = 1'b1;
    prediction = 1'b1;
    #1;
    chk("bne_flush", 32'(flush), 32'd0);
    chk("bne_bp_taken", 32'(BP_TAKEN), 32'd1);
    tick;
    // beq not taken, predicted taken.
    ALU_OUT = 32'd3;
    MEM_CTRL[BRANCH_SENSE_BIT] = 1'b0;
    #1;
    chk("beq_nt_flush", 32'(flush), 32'd1);
    chk("beq_nt_pc", PC_RECOVER, 32'h0000_0204);
    tick;
    set_nop(32'h0, 5'd1);
    #1;
    chk("nobr_flush", 32'(flush), 32'd0);
    chk("nobr_update", 32'(BP_UPDATE), 32'd0);
    chk("nobr_pc", PC_RECOVER, 32'h0);
    tick;

    // Load never acked: times out after 64 WAIT cycles.
    set_load(32'h0000_0300, 5'd6);
    DMEM_RDATA = 32'h1111_2222;
    n = 0;
    while (n < 200) begin
      #1;
      if (!cache_stall) break;
      n++;
      tick;
    end
    chk("to_stall_cycles", n, 32'd65);
    chk("to_bus_err", 32'(BUS_ERR), 32'd1);
    tick;
    chk("to_reg_mem", REG_MEM_OUT, 32'h0);
    chk("to_reg_alu", REG_ALU_OUT, 32'h0000_0300);
    set_load(32'h0000_0400, 5'd6);
    DMEM_ACK = 1'b1;
    #1;
    chk("to_back_idle_req", 32'(DMEM_REQ), 32'd1);
    tick;
    DMEM_ACK = 1'b0;
    tick;
    chk("to_bus_err_sticky", 32'(BUS_ERR), 32'd1);

    // Reset asserted mid-WAIT.
    set_load(32'h0000_0500, 5'd8);
    tick;
    tick;
    chk("rw_req_before", 32'(DMEM_REQ), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_req", 32'(DMEM_REQ), 32'd0);
    chk("rw_stall", 32'(cache_stall), 32'd0);
    chk("rw_reg_alu", REG_ALU_OUT, 32'h0);
    chk("rw_reg_mem", REG_MEM_OUT, 32'h0);
    chk("rw_reg_wr", 32'(REG_WRITE_REG), 32'd0);
    chk("rw_reg_wb", 32'(REG_WB_CTRL), 32'd0);
    chk("rw_bus_err", 32'(BUS_ERR), 32'd0);
    tick;
    set_nop(32'h0000_0077, 5'd5);
    reset = 1'b1;
    #1;
    chk("post_rst_stall", 32'(cache_stall), 32'd0);
    tick;
    chk("post_rst_alu", REG_ALU_OUT, 32'h0000_0077);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
